wave_cfg_sequencer: RTL and testbench

WAVE_CFG_SEQUENCER -- requirements
Module: wave_cfg_sequencer

---
 rtl/wave_cfg_sequencer.sv | 165 ++++++++++++++++
 tb/tb_wave_cfg_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_cfg_sequencer.sv
// Command sequencer: writes a per-slot start-address table out to the channel
// address controllers, then raises a one-hot request and a completion pulse.
module wave_cfg_sequencer #(
    parameter int NCH    = 12,
    parameter int WR_GAP = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [3:0]  cmd_base,
    input  logic        cmd_abort,
    input  logic        tbl_wr,
    input  logic [3:0]  tbl_addr,
    input  logic [7:0]  tbl_data,
    input  logic        hst_wren,
    input  logic [7:0]  hst_addr,
    input  logic [7:0]  hst_data,
    output logic        hst_rej,
    output logic        w_wren_o,
    output logic [7:0]  w_addr_o,
    output logic [7:0]  w_data_o,
    output logic [10:0] req_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {IDLE, WRITE, GAP, REQ, DONE} state_t;

    localparam logic [3:0] LAST_SLOT = 4'(NCH - 1);
    localparam logic [3:0] GAP_LAST  = 4'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    state_t     state;
    logic [7:0] tbl [12];
    logic [3:0] op_q;
    logic [3:0] base_q;
    logic [3:0] slot;
    logic [3:0] gap_cnt;
    logic [3:0] next_slot;
    logic       accept;
    logic       op_writes;

    assign next_slot = slot + 4'd1;
    assign cmd_ready = (state == IDLE) && !hst_wren;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        op_writes = 1'b0;
        case (cmd_op)
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10: op_writes = 1'b1;
            default: op_writes = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            op_q     <= '0;
            base_q   <= '0;
            slot     <= '0;
            gap_cnt  <= '0;
            hst_rej  <= 1'b0;
            w_wren_o <= 1'b0;
            w_addr_o <= '0;
            w_data_o <= '0;
            req_o    <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            for (int unsigned i = 0; i < 12; i++) tbl[i] <= '0;
        end else begin
            hst_rej  <= 1'b0;
            w_wren_o <= 1'b0;
            req_o    <= '0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;

            // Table reads below see the pre-edge contents, so a same-cycle
            // load of the slot being issued sends the old value.
            if (tbl_wr && (tbl_addr < 4'd12)) tbl[tbl_addr] <= tbl_data;

            if (hst_wren && (state != IDLE)) hst_rej <= 1'b1;

            case (state)
                IDLE: begin
                    if (hst_wren) begin
                        w_wren_o <= 1'b1;
                        w_addr_o <= hst_addr;
                        w_data_o <= hst_data;
                    end else if (accept) begin
                        slot    <= '0;
                        gap_cnt <= '0;
                        if (cmd_op > 4'd10) begin
                            err_o <= 1'b1;
                        end else if (op_writes) begin
                            op_q     <= cmd_op;
                            base_q   <= cmd_base;
                            w_wren_o <= 1'b1;
                            w_addr_o <= {4'd0, cmd_base};
                            w_data_o <= tbl[0];
                            state    <= WRITE;
                            busy_o   <= 1'b1;
                        end else begin
                            op_q   <= cmd_op;
                            req_o  <= 11'd1 << cmd_op;
                            state  <= REQ;
                            busy_o <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (cmd_abort) begin
                        err_o  <= 1'b1;
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (WR_GAP != 0) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (slot == LAST_SLOT) begin
                        req_o <= 11'd1 << op_q;
                        state <= REQ;
                    end else begin
                        slot     <= next_slot;
                        w_wren_o <= 1'b1;
                        w_addr_o <= {next_slot, base_q};
                        w_data_o <= tbl[next_slot];
                    end
                end
                GAP: begin
                    if (cmd_abort) begin
                        err_o  <= 1'b1;
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end else if (slot == LAST_SLOT) begin
                        req_o <= 11'd1 << op_q;
                        state <= REQ;
                    end else begin
                        slot     <= next_slot;
                        w_wren_o <= 1'b1;
                        w_addr_o <= {next_slot, base_q};
                        w_data_o <= tbl[next_slot];
                        state    <= WRITE;
                    end
                end
                REQ: begin
                    done_o <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_cfg_sequencer.sv
// Scoreboard bench for wave_cfg_sequencer: expected bus events are queued with
// their cycle numbers when stimulus is driven and matched by a negedge monitor.
module tb_wave_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [3:0]  cmd_base = '0;
    logic        cmd_abort = 1'b0;
    logic        tbl_wr = 1'b0;
    logic [3:0]  tbl_addr = '0;
    logic [7:0]  tbl_data = '0;
    logic        hst_wren = 1'b0;
    logic [7:0]  hst_addr = '0;
    logic [7:0]  hst_data = '0;
    logic        hst_rej;
    logic        w_wren_o;
    logic [7:0]  w_addr_o;
    logic [7:0]  w_data_o;
    logic [10:0] req_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    wave_cfg_sequencer #(.NCH(12), .WR_GAP(2)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_abort(cmd_abort),
        .tbl_wr(tbl_wr), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .hst_wren(hst_wren), .hst_addr(hst_addr), .hst_data(hst_data),
        .hst_rej(hst_rej), .w_wren_o(w_wren_o), .w_addr_o(w_addr_o),
        .w_data_o(w_data_o), .req_o(req_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Event kinds: 0 bus write, 1 request, 2 done, 3 error, 4 host reject.
    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] val;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;
    logic [7:0] mtbl [12];

    always @(posedge clk) cyc++;

    function automatic string kname(input int k);
        case (k)
            0: return "write";
            1: return "req";
            2: return "done";
            3: return "err";
            default: return "hst_rej";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int c, input logic [15:0] v);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input int kind, input logic [15:0] v);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].kind == kind && exp_q[i].cyc == cyc) idx = i;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_%s at cycle %0d: got %h, required no event", kname(kind), cyc, v);
        end else begin
            if (exp_q[idx].val !== v) begin
                errors++;
                $display("FAIL %s_value at cycle %0d: got %h, required %h", kname(kind), cyc, v, exp_q[idx].val);
            end
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rstn) begin
            if (w_wren_o) match_ev(0, {w_addr_o, w_data_o});
            if (|req_o)   match_ev(1, {5'd0, req_o});
            if (done_o)   match_ev(2, 16'd0);
            if (err_o)    match_ev(3, 16'd0);
            if (hst_rej)  match_ev(4, 16'd0);
            checks++;
            if ((int'(|req_o) + int'(done_o) + int'(err_o)) > 1 || $countones(req_o) > 1) begin
                errors++;
                $display("FAIL exclusive_pulses at cycle %0d: got req=%h done=%b err=%b, required at most one", cyc, req_o, done_o, err_o);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a command and returns the cycle it was accepted in (-1 on timeout).
    task automatic issue(input logic [3:0] op, input logic [3:0] base, output int t);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base;
        t = -1;
        for (int i = 0; i < 60 && t < 0; i++) begin
            @(negedge clk);
            if (cmd_ready) t = cyc;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no cmd_ready, required acceptance of op %0d", op);
        end
    endtask

    // Default geometry: 12 slots, one write every 3 cycles, req at T+37.
    task automatic expect_seq(input logic [3:0] op, input logic [3:0] base, input int t,
                              input int nwr, input bit full);
        for (int k = 0; k < nwr; k++)
            expect_ev(0, t + 1 + k * 3, {4'(k), base, mtbl[k]});
        if (full) begin
            expect_ev(1, t + 37, 16'(11'd1 << op));
            expect_ev(2, t + 38, 16'd0);
        end
    endtask

    task automatic drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d events unseen (first %s at cycle %0d), required 0",
                     name, exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({hst_rej, w_wren_o, w_addr_o, w_data_o, req_o, busy_o, done_o, err_o} !== '0) begin
            errors++;
            $display("FAIL %s: got wren=%b addr=%h data=%h req=%h busy=%b done=%b err=%b rej=%b, required all 0",
                     name, w_wren_o, w_addr_o, w_data_o, req_o, busy_o, done_o, err_o, hst_rej);
        end
    endtask

    task automatic test_reset();
        int c;
        int t;
        rstn = 1'b0;
        tick(2);
        check_outputs_zero("reset_outputs");
        for (int k = 0; k < 12; k++) mtbl[k] = 8'h00;
        rstn   = 1'b1;
        c      = cyc;
        mon_en = 1'b1;
        issue(4'd0, 4'd0, t);
        checks++;
        if (t !== c) begin
            errors++;
            $display("FAIL first_accept: got cycle %0d, required %0d", t, c);
        end
        expect_ev(1, t + 1, 16'h0001);
        expect_ev(2, t + 2, 16'd0);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: got %b, required 1", busy_o);
        end
        tick(4);
        drain("reset_poweron");
    endtask

    task automatic test_table_load();
        for (int k = 0; k < 16; k++) begin
            tbl_wr   = 1'b1;
            tbl_addr = 4'(k);
            tbl_data = (k < 12) ? 8'(8'h10 + k) : 8'hFF;
            if (k < 12) mtbl[k] = 8'(8'h10 + k);
            tick(1);
        end
        tbl_wr = 1'b0;
    endtask

    task automatic test_write_seq();
        int t;
        logic [3:0] ops   [2] = '{4'd2, 4'd9};
        logic [3:0] bases [2] = '{4'h3, 4'hA};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], bases[i], t);
            expect_seq(ops[i], bases[i], t, 12, 1'b1);
            tick(40);
            drain("write_seq");
        end
    endtask

    task automatic test_no_write_op();
        int t;
        logic [3:0] ops [4] = '{4'd7, 4'd0, 4'd1, 4'd8};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 4'h5, t);
            expect_ev(1, t + 1, 16'(11'd1 << ops[i]));
            expect_ev(2, t + 2, 16'd0);
            tick(4);
            drain("no_write_op");
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        issue(4'd7, 4'h0, t1);
        expect_ev(1, t1 + 1, 16'h0080);
        expect_ev(2, t1 + 2, 16'd0);
        issue(4'd8, 4'h0, t2);
        checks++;
        if (t2 !== t1 + 3) begin
            errors++;
            $display("FAIL back_to_back_accept: got cycle %0d, required %0d", t2, t1 + 3);
        end
        expect_ev(1, t2 + 1, 16'h0100);
        expect_ev(2, t2 + 2, 16'd0);
        tick(4);
        drain("back_to_back");
    endtask

    task automatic test_bad_op();
        int t;
        logic [3:0] ops [2] = '{4'hF, 4'hB};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 4'h1, t);
            expect_ev(3, t + 1, 16'd0);
            checks++;
            if (cmd_ready !== 1'b1 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL bad_op_idle: got ready=%b busy=%b, required ready=1 busy=0", cmd_ready, busy_o);
            end
            tick(3);
            drain("bad_op");
        end
    endtask

    task automatic test_host_priority();
        int h;
        int t;
        hst_wren  = 1'b1;
        hst_addr  = 8'hAA;
        hst_data  = 8'h55;
        cmd_valid = 1'b1;
        cmd_op    = 4'd7;
        @(negedge clk);
        h = cyc;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL host_priority_ready: got %b, required 0", cmd_ready);
        end
        expect_ev(0, h + 1, 16'hAA55);
        @(posedge clk);
        #1;
        hst_wren = 1'b0;
        issue(4'd7, 4'h0, t);
        checks++;
        if (t !== h + 1) begin
            errors++;
            $display("FAIL host_priority_accept: got cycle %0d, required %0d", t, h + 1);
        end
        expect_ev(1, t + 1, 16'h0080);
        expect_ev(2, t + 2, 16'd0);
        tick(4);
        drain("host_priority");
    endtask

    task automatic test_host_reject();
        int t;
        issue(4'd4, 4'h5, t);
        expect_seq(4'd4, 4'h5, t, 12, 1'b1);
        tick(3);
        hst_wren = 1'b1;
        hst_addr = 8'hC3;
        hst_data = 8'h3C;
        expect_ev(4, t + 5, 16'd0);
        tick(1);
        hst_wren = 1'b0;
        tick(38);
        drain("host_reject");
    endtask

    task automatic test_abort();
        int t;
        issue(4'd3, 4'h9, t);
        expect_seq(4'd3, 4'h9, t, 3, 1'b0);
        expect_ev(3, t + 8, 16'd0);
        tick(6);
        cmd_abort = 1'b1;
        tick(1);
        cmd_abort = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b ready=%b, required busy=0 ready=1", busy_o, cmd_ready);
        end
        tick(42);
        drain("abort_write");
        cmd_abort = 1'b1;
        issue(4'd0, 4'h0, t);
        expect_ev(1, t + 1, 16'h0001);
        expect_ev(2, t + 2, 16'd0);
        tick(2);
        cmd_abort = 1'b0;
        tick(2);
        drain("abort_ignored");
    endtask

    task automatic test_tbl_collision();
        int t;
        issue(4'd5, 4'h1, t);
        expect_seq(4'd5, 4'h1, t, 12, 1'b1);
        tick(2);
        tbl_wr   = 1'b1;
        tbl_addr = 4'd1;
        tbl_data = 8'hEE;
        tick(1);
        tbl_wr  = 1'b0;
        mtbl[1] = 8'hEE;
        tick(38);
        drain("tbl_collision_old");
        issue(4'd6, 4'h2, t);
        expect_seq(4'd6, 4'h2, t, 12, 1'b1);
        tick(40);
        drain("tbl_collision_new");
    endtask

    task automatic test_reset_mid();
        int t;
        int c;
        mon_en = 1'b0;
        issue(4'd2, 4'h0, t);
        tick(3);
        #2;
        rstn = 1'b0;
        #1;
        check_outputs_zero("reset_mid_outputs");
        exp_q.delete();
        for (int k = 0; k < 12; k++) mtbl[k] = 8'h00;
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        c      = cyc;
        mon_en = 1'b1;
        issue(4'd2, 4'h0, t);
        checks++;
        if (t !== c) begin
            errors++;
            $display("FAIL reset_mid_accept: got cycle %0d, required %0d", t, c);
        end
        expect_seq(4'd2, 4'h0, t, 12, 1'b1);
        tick(40);
        drain("reset_mid_table");
    endtask

    initial begin
        for (int k = 0; k < 12; k++) mtbl[k] = 8'h00;
        test_reset();
        test_table_load();
        test_write_seq();
        test_no_write_op();
        test_back_to_back();
        test_bad_op();
        test_host_priority();
        test_host_reject();
        test_abort();
        test_tbl_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns, required $finish");
        $fatal(1);
    end

endmodule
